mips_multicycle_control: RTL and testbench

Multi-cycle MIPS control unit that replaces the single-cycle decoder with a Moore state machine. It sequences fetch, decode, execute, memory and write-back over several clocks for R-format, LW, SW, BEQ, J and ORI. It adds memory wait-state handshaking, a retired-instruction counter and configurable illegal-opcode handling. It sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath muxes and write enables.

---
 rtl/mips_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
//
// Purpose:
//   Moore-style control unit for a shared-memory multi-cycle MIPS datapath.
//   It steps R-format, LW, SW, BEQ, J and ORI through fetch, decode, execute,
//   memory and write-back states. Memory states can stall on a ready
//   handshake. A counter tracks retired instructions.
//
// Optional feature (compile-time macro):
//   MC_CTRL_ILLEGAL_TRAP_EN
//     - defined   : an unknown opcode enters TRAP. TRAP drives every control
//                   low, raises illegal_op and holds until rst.
//     - undefined : an unknown opcode retires as a NOP straight from DECODE.
//                   illegal_op is tied low and TRAP is never entered.
//
// Parameters:
//   MEM_WAIT     : 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = never wait
//   RET_W        : width of retire_count
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   opcode[5:0]  in   IR[31:26], used in DECODE and MEMADR
//   mem_ready    in   memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   ALUSrcA, RegWrite, RegDst           out  datapath controls
//   PCSource[1:0] out 00 ALU result, 01 ALUOut, 10 jump target
//   ALUSrcB[1:0]  out 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUOp[1:0]    out 00 add, 01 sub, 10 funct field, 11 or
//   state[3:0]    out current state code (debug)
//   instr_retired out one-cycle pulse as an instruction completes
//   retire_count  out retired-instruction count, wraps
//   illegal_op    out trap flag
// -----------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter bit          MEM_WAIT = 1'b1,
  parameter int unsigned RET_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             instr_retired,
  output logic [RET_W-1:0] retire_count,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t           r_state;
  state_t           w_next;
  logic             w_rdy;
  logic             w_retire;
  logic [RET_W-1:0] r_retire_count;

  // With MEM_WAIT=0 the memory is assumed single-cycle.
  assign w_rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and retire pulse. A retire is flagged on every transition
  // back to FETCH that ends an instruction. The FETCH self-loop does not
  // retire, and neither does the recovery path from illegal encodings.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_rdy) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_ORI:       w_next = S_ORIEX;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            w_next   = S_TRAP;
`else
            // Unknown opcode retires as a NOP.
            w_next   = S_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        // The IR still holds the instruction, so opcode is valid here.
        if (opcode == OP_LW) begin
          w_next = S_MEMRD;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (w_rdy) begin
          w_next = S_MEMWB;
        end else begin
          w_next = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (w_rdy) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next   = S_MEMWR;
        end
      end
      S_EXEC:  w_next = S_RWB;
      S_ORIEX: w_next = S_ORIWB;
      S_RWB, S_MEMWB, S_ORIWB, S_BEQ, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        // Only rst leaves TRAP.
        w_next = S_TRAP;
`else
        w_next = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Moore output decode. Every control starts at 0, and each state raises
  // only the controls it uses.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Load the IR and advance the PC only in the cycle the read lands.
        IRWrite = w_rdy;
        PCWrite = w_rdy;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ORIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_ORIWB: begin
        RegWrite = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  // Retired-instruction counter. It wraps naturally at 2^RET_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (w_retire) begin
      r_retire_count <= r_retire_count + RET_W'(1);
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  assign state         = r_state;
  assign instr_retired = w_retire;
  assign retire_count  = r_retire_count;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic        instr_retired;
  logic [31:0] retire_count;
  logic        illegal_op;
  logic [15:0] ctrl;

  int n_total;
  int n_bad;

  mips_multicycle_control #(.MEM_WAIT(1'b1), .RET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .instr_retired(instr_retired),
    .retire_count(retire_count), .illegal_op(illegal_op)
  );

  // Packed control word:
  // [15]PCWrite [14]PCWriteCond [13]IorD [12]MemRead [11]MemWrite [10]IRWrite
  // [9]MemtoReg [8]ALUSrcA [7]RegWrite [6]RegDst [5:4]PCSource [3:2]ALUSrcB [1:0]ALUOp
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

  localparam logic [15:0] C_FETCH_RDY  = 16'h9404;
  localparam logic [15:0] C_FETCH_WAIT = 16'h1004;
  localparam logic [15:0] C_DECODE     = 16'h000C;
  localparam logic [15:0] C_MEMADR     = 16'h0108;
  localparam logic [15:0] C_MEMRD      = 16'h3000;
  localparam logic [15:0] C_MEMWB      = 16'h0280;
  localparam logic [15:0] C_MEMWR      = 16'h2800;
  localparam logic [15:0] C_EXEC       = 16'h0102;
  localparam logic [15:0] C_RWB        = 16'h00C0;
  localparam logic [15:0] C_BEQ        = 16'h4111;
  localparam logic [15:0] C_JUMP       = 16'h8020;
  localparam logic [15:0] C_ORIEX      = 16'h010B;
  localparam logic [15:0] C_ORIWB      = 16'h0080;
  localparam logic [15:0] C_ZERO       = 16'h0000;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ret;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [3:0] st, input logic [15:0] c,
                              input logic ret, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = c; v.ret = ret; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    logic        ret63;
    logic [31:0] exp_cnt;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b0;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ret63 = 1'b0;
`else
    ret63 = 1'b1;
`endif

    // Reset, then an R-format instruction.
    vecs.push_back(mk(1'b1, 6'd0,  1'b0, 4'd0,  C_FETCH_WAIT, 1'b0, 32'd0));
    vecs.push_back(mk(1'b0, 6'd0,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd0));
    vecs.push_back(mk(1'b0, 6'd0,  1'b1, 4'd1,  C_DECODE,     1'b0, 32'd0));
    vecs.push_back(mk(1'b0, 6'd0,  1'b0, 4'd6,  C_EXEC,       1'b0, 32'd0));
    vecs.push_back(mk(1'b0, 6'd0,  1'b1, 4'd7,  C_RWB,        1'b1, 32'd0));
    // LW with two wait states in MEMRD.
    vecs.push_back(mk(1'b0, 6'd35, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b1, 4'd1,  C_DECODE,     1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b1, 4'd2,  C_MEMADR,     1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b0, 4'd3,  C_MEMRD,      1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b0, 4'd3,  C_MEMRD,      1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b1, 4'd3,  C_MEMRD,      1'b0, 32'd1));
    vecs.push_back(mk(1'b0, 6'd35, 1'b1, 4'd4,  C_MEMWB,      1'b1, 32'd1));
    // SW with one wait in MEMWR; mem_ready low in DECODE is ignored.
    vecs.push_back(mk(1'b0, 6'd43, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd2));
    vecs.push_back(mk(1'b0, 6'd43, 1'b0, 4'd1,  C_DECODE,     1'b0, 32'd2));
    vecs.push_back(mk(1'b0, 6'd43, 1'b1, 4'd2,  C_MEMADR,     1'b0, 32'd2));
    vecs.push_back(mk(1'b0, 6'd43, 1'b0, 4'd5,  C_MEMWR,      1'b0, 32'd2));
    vecs.push_back(mk(1'b0, 6'd43, 1'b1, 4'd5,  C_MEMWR,      1'b1, 32'd2));
    // BEQ.
    vecs.push_back(mk(1'b0, 6'd4,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd3));
    vecs.push_back(mk(1'b0, 6'd4,  1'b0, 4'd1,  C_DECODE,     1'b0, 32'd3));
    vecs.push_back(mk(1'b0, 6'd4,  1'b1, 4'd8,  C_BEQ,        1'b1, 32'd3));
    // J.
    vecs.push_back(mk(1'b0, 6'd2,  1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd4));
    vecs.push_back(mk(1'b0, 6'd2,  1'b1, 4'd1,  C_DECODE,     1'b0, 32'd4));
    vecs.push_back(mk(1'b0, 6'd2,  1'b1, 4'd9,  C_JUMP,       1'b1, 32'd4));
    // ORI.
    vecs.push_back(mk(1'b0, 6'd15, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd5));
    vecs.push_back(mk(1'b0, 6'd15, 1'b1, 4'd1,  C_DECODE,     1'b0, 32'd5));
    vecs.push_back(mk(1'b0, 6'd15, 1'b0, 4'd10, C_ORIEX,      1'b0, 32'd5));
    vecs.push_back(mk(1'b0, 6'd15, 1'b1, 4'd11, C_ORIWB,      1'b1, 32'd5));
    // Fetch wait, then decode of unknown opcode 63.
    vecs.push_back(mk(1'b0, 6'd63, 1'b0, 4'd0,  C_FETCH_WAIT, 1'b0, 32'd6));
    vecs.push_back(mk(1'b0, 6'd63, 1'b1, 4'd0,  C_FETCH_RDY,  1'b0, 32'd6));
    vecs.push_back(mk(1'b0, 6'd63, 1'b1, 4'd1,  C_DECODE,     ret63, 32'd6));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].op, vecs[i].rdy);
      check($sformatf("v%0d_state", i),   {28'd0, state},          {28'd0, vecs[i].st});
      check($sformatf("v%0d_ctrl", i),    {16'd0, ctrl},           {16'd0, vecs[i].ctrl});
      check($sformatf("v%0d_retired", i), {31'd0, instr_retired},  {31'd0, vecs[i].ret});
      check($sformatf("v%0d_count", i),   retire_count,            vecs[i].cnt);
      check($sformatf("v%0d_illegal", i), {31'd0, illegal_op},     32'd0);
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // TRAP holds for 10 cycles whatever mem_ready does.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 6'd0, 1'($urandom_range(0, 1)));
      check($sformatf("trap%0d_state", k),   {28'd0, state},         32'd12);
      check($sformatf("trap%0d_illegal", k), {31'd0, illegal_op},    32'd1);
      check($sformatf("trap%0d_ctrl", k),    {16'd0, ctrl},          {16'd0, C_ZERO});
      check($sformatf("trap%0d_retired", k), {31'd0, instr_retired}, 32'd0);
      check($sformatf("trap%0d_count", k),   retire_count,           32'd6);
    end
    cyc(1'b1, 6'd0, 1'b0);
    check("trap_rst_state",   {28'd0, state},      32'd0);
    check("trap_rst_illegal", {31'd0, illegal_op}, 32'd0);
    check("trap_rst_count",   retire_count,        32'd0);
    exp_cnt = 32'd0;
`else
    // The NOP retired from DECODE; hold in FETCH with mem_ready low.
    cyc(1'b0, 6'd0, 1'b0);
    check("nop_state", {28'd0, state},  32'd0);
    check("nop_count", retire_count,    32'd7);
    check("nop_ctrl",  {16'd0, ctrl},   {16'd0, C_FETCH_WAIT});
    exp_cnt = 32'd7;
`endif

    // One R-format instruction to advance the count.
    cyc(1'b0, 6'd0, 1'b1);
    check("r2_fetch_state", {28'd0, state}, 32'd0);
    cyc(1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b1);
    check("r2_rwb_retired", {31'd0, instr_retired}, 32'd1);
    exp_cnt = exp_cnt + 32'd1;

    // LW up to MEMRD, then reset in the middle of a wait cycle.
    cyc(1'b0, 6'd35, 1'b1);
    check("lw2_fetch_count", retire_count, exp_cnt);
    cyc(1'b0, 6'd35, 1'b1);
    cyc(1'b0, 6'd35, 1'b1);
    cyc(1'b0, 6'd35, 1'b0);
    check("lw2_memrd_state", {28'd0, state}, 32'd3);
    check("lw2_memrd_ctrl",  {16'd0, ctrl},  {16'd0, C_MEMRD});
    #2;
    rst = 1'b1;
    #1;
    check("midrst_state",   {28'd0, state},         32'd0);
    check("midrst_count",   retire_count,           32'd0);
    check("midrst_ctrl",    {16'd0, ctrl},          {16'd0, C_FETCH_WAIT});
    check("midrst_retired", {31'd0, instr_retired}, 32'd0);
    check("midrst_illegal", {31'd0, illegal_op},    32'd0);
    cyc(1'b0, 6'd0, 1'b1);
    check("postrst_ctrl",  {16'd0, ctrl}, {16'd0, C_FETCH_RDY});
    check("postrst_count", retire_count,  32'd0);
    cyc(1'b0, 6'd0, 1'b1);
    check("postrst_decode", {28'd0, state}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
